// File: rtl/detect_tally_display.sv
// Board-clock consumer of the 010110 detector: synchronises Z/clear, keeps a BCD
// tally of detections and scans the tally plus detector state onto the 7-seg display.
module detect_tally_display #(
  parameter int SYNC_STAGES = 2,
  parameter int REFRESH_DIV = 100000,
  parameter int HIT_HOLD    = 25000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Z,
  input  logic [2:0]  Q,
  input  logic        clear,
  output logic        hit,
  output logic [15:0] count,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  // slot    | meaning
  // SLOT_D0 | drive digit 0 with tally units, dp shows hit flash
  // SLOT_D1 | drive digit 1 with tally tens
  // SLOT_D2 | drive digit 2 with tally hundreds
  // SLOT_D3 | drive digit 3 with tally thousands
  // SLOT_Q  | drive digit 7 with detector state Q as an octal glyph
  typedef enum logic [2:0] {SLOT_D0, SLOT_D1, SLOT_D2, SLOT_D3, SLOT_Q} slot_t;

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int HW = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HIT_HOLD - 1);

  logic [SYNC_STAGES-1:0] z_sync, c_sync;
  logic [2:0]             q_s1, q_s2;
  logic                   zs, cs, zd;
  logic [RW-1:0]          ref_cnt;
  logic [HW-1:0]          hold_cnt;
  slot_t                  slot_q, slot_d;
  logic [7:0]             an_d;
  logic [6:0]             seg_d;
  logic                   dp_d;
  logic [3:0]             digit;

  assign zs = z_sync[SYNC_STAGES-1];
  assign cs = c_sync[SYNC_STAGES-1];

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      z_sync <= '0;
      c_sync <= '0;
      q_s1   <= '0;
      q_s2   <= '0;
      zd     <= 1'b0;
      hit    <= 1'b0;
    end else begin
      z_sync <= {z_sync[SYNC_STAGES-2:0], Z};
      c_sync <= {c_sync[SYNC_STAGES-2:0], clear};
      q_s1   <= Q;
      q_s2   <= q_s1;
      zd     <= zs;
      hit    <= zs & ~zd;
    end
  end

  // Clear dominates: a hit landing while clear is active is discarded.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count    <= '0;
      hold_cnt <= '0;
      ref_cnt  <= '0;
    end else begin
      if (cs)       count <= '0;
      else if (hit) count <= bcd_inc(count);

      if (hit)                 hold_cnt <= HOLD_LOAD;
      else if (hold_cnt != '0) hold_cnt <= hold_cnt - HW'(1);

      if (ref_cnt == REF_LAST) ref_cnt <= '0;
      else                     ref_cnt <= ref_cnt + RW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_q <= SLOT_D0;
      an     <= 8'hFF;
      seg    <= 7'h7F;
      dp     <= 1'b1;
    end else begin
      slot_q <= slot_d;
      an     <= an_d;
      seg    <= seg_d;
      dp     <= dp_d;
    end
  end

  always_comb begin
    slot_d = slot_q;
    an_d   = 8'hFF;
    digit  = 4'hF;
    if (ref_cnt == REF_LAST) begin
      case (slot_q)
        SLOT_D0: slot_d = SLOT_D1;
        SLOT_D1: slot_d = SLOT_D2;
        SLOT_D2: slot_d = SLOT_D3;
        SLOT_D3: slot_d = SLOT_Q;
        default: slot_d = SLOT_D0;
      endcase
    end
    case (slot_q)
      SLOT_D0: begin an_d = 8'hFE; digit = count[3:0];   end
      SLOT_D1: begin an_d = 8'hFD; digit = count[7:4];   end
      SLOT_D2: begin an_d = 8'hFB; digit = count[11:8];  end
      SLOT_D3: begin an_d = 8'hF7; digit = count[15:12]; end
      SLOT_Q:  begin an_d = 8'h7F; digit = {1'b0, q_s2}; end
      default: begin an_d = 8'hFF; digit = 4'hF;         end
    endcase
    seg_d = glyph(digit);
    dp_d  = ~((slot_q == SLOT_D0) && ((hold_cnt != '0) || hit));
  end

endmodule

// File: tb/tb_detect_tally_display.sv
// Randomised and directed bench for detect_tally_display against a cycle-indexed
// reference model built from integer tally arithmetic and input-sample histories.
module tb_detect_tally_display;
  localparam int SYNC = 2;
  localparam int RDIV = 4;
  localparam int HOLD = 8;
  localparam logic [6:0] GLYPH [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam int P10 [0:3] = '{1, 10, 100, 1000};

  logic        clock = 1'b0;
  logic        reset, Z, clear;
  logic [2:0]  Q;
  logic        hit, dp;
  logic [15:0] count;
  logic [7:0]  an;
  logic [6:0]  seg;

  always #5 clock = ~clock;

  detect_tally_display #(.SYNC_STAGES(SYNC), .REFRESH_DIV(RDIV), .HIT_HOLD(HOLD)) dut (
    .clock(clock), .reset(reset), .Z(Z), .Q(Q), .clear(clear),
    .hit(hit), .count(count), .an(an), .seg(seg), .dp(dp));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state: n = clock edges since reset release; tally kept as a plain integer.
  int         n, mcount, last_hit;
  bit         mhit;
  bit         zq[$];
  bit         cq[$];
  logic [2:0] qq[$];
  logic [7:0] e_an;
  logic [6:0] e_seg;
  bit         e_dp;

  function automatic bit zago(int k);
    return (k < zq.size()) ? zq[k] : 1'b0;
  endfunction
  function automatic bit cago(int k);
    return (k < cq.size()) ? cq[k] : 1'b0;
  endfunction
  function automatic logic [2:0] qago(int k);
    return (k < qq.size()) ? qq[k] : 3'd0;
  endfunction
  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    n = 0; mcount = 0; mhit = 1'b0; last_hit = -1;
    zq.delete(); cq.delete(); qq.delete();
  endtask

  task automatic model_edge();
    int slot;
    bit hold_on, cs_now, new_hit;
    slot    = (n / RDIV) % 5;
    hold_on = (last_hit >= 0) && (n - last_hit < HOLD);
    if (slot == 4) begin
      e_an  = 8'h7F;
      e_seg = GLYPH[int'(qago(1))];
    end else begin
      e_an  = ~(8'h01 << slot);
      e_seg = GLYPH[(mcount / P10[slot]) % 10];
    end
    e_dp    = !(slot == 0 && hold_on);
    cs_now  = cago(SYNC - 1);
    new_hit = zago(SYNC - 1) & ~zago(SYNC);
    if (cs_now)    mcount = 0;
    else if (mhit) mcount = (mcount + 1) % 10000;
    mhit = new_hit;
    n++;
    if (mhit) last_hit = n;
    zq.push_front(Z); cq.push_front(clear); qq.push_front(Q);
    if (zq.size() > 8) begin
      void'(zq.pop_back()); void'(cq.pop_back()); void'(qq.pop_back());
    end
  endtask

  task automatic check_outputs();
    if (reset) begin
      check("rst_hit", 32'(hit), 32'd0);
      check("rst_count", 32'(count), 32'h0);
      check("rst_an", 32'(an), 32'hFF);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_dp", 32'(dp), 32'd1);
    end else begin
      check("hit", 32'(hit), 32'(mhit));
      check("count", 32'(count), 32'(to_bcd(mcount)));
      check("an", 32'(an), 32'(e_an));
      check("seg", 32'(seg), 32'(e_seg));
      check("dp", 32'(dp), 32'(e_dp));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) model_edge();
    @(negedge clock);
    check_outputs();
  endtask

  task automatic pulse();
    Z = 1'b1; tick();
    Z = 1'b0; tick();
  endtask

  initial begin
    int hits, first_hit, starts, s1, s2;
    logic [7:0] prev_an;
    bit found;

    reset = 1'b1; Z = 1'b0; clear = 1'b0; Q = 3'd0;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    tick(); tick();
    check("an_after_rst", 32'(an), 32'hFE);
    check("seg_after_rst", 32'(seg), 32'(7'b1000000));

    // Single long Z high: one pulse, SYNC+1 clocks after the rise.
    Z = 1'b1; hits = 0; first_hit = -1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (hit === 1'b1) begin
        hits++;
        if (first_hit < 0) first_hit = i + 1;
      end
    end
    check("one_hit", 32'(hits), 32'd1);
    check("hit_latency", 32'(first_hit), 32'd3);
    check("count_1", 32'(count), 32'h0001);
    Z = 1'b0; repeat (4) tick();

    repeat (8) pulse();
    repeat (4) tick();
    check("count_9", 32'(count), 32'h0009);
    repeat (10) pulse();
    repeat (4) tick();
    check("count_19", 32'(count), 32'h0019);

    repeat (9980) pulse();
    repeat (4) tick();
    check("count_9999", 32'(count), 32'h9999);
    pulse();
    repeat (4) tick();
    check("count_wrap", 32'(count), 32'h0000);

    // Hit and synchronised clear land on the same cycle; clear wins.
    repeat (123) pulse();
    repeat (4) tick();
    check("count_123", 32'(count), 32'h0123);
    Z = 1'b1; tick();
    clear = 1'b1;
    repeat (10) tick();
    check("clear_held", 32'(count), 32'h0000);
    Z = 1'b0; clear = 1'b0;
    repeat (6) tick();
    check("clear_hit_lost", 32'(count), 32'h0000);

    // Q display and scan order.
    Q = 3'd5; repeat (3) tick();
    starts = 0; s1 = 0; s2 = 0; prev_an = an;
    for (int i = 0; i < 45; i++) begin
      tick();
      check("an_unused", 32'(an[6:4]), 32'h7);
      if (an == 8'h7F) check("seg_q5", 32'(seg), 32'(7'b0010010));
      if (an == 8'hFE && prev_an != 8'hFE) begin
        starts++;
        if (starts == 1) s1 = i;
        if (starts == 2) s2 = i;
      end
      prev_an = an;
    end
    if (starts >= 2) check("an_period", 32'(s2 - s1), 32'd20);
    else             check("an_starts", 32'(starts), 32'd2);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) Z = ~Z;
      clear = ($urandom_range(0, 49) == 0);
      Q = 3'($urandom_range(0, 7));
      tick();
    end
    Z = 1'b0; clear = 1'b0;
    repeat (4) tick();

    // Async reset in the middle of slot 2 while the hit flash is active.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      Z = ~Z;
      tick();
      if (an == 8'hFB) found = 1'b1;
    end
    check("reach_slot2", 32'(found), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_an", 32'(an), 32'hFF);
    check("async_dp", 32'(dp), 32'd1);
    check("async_count", 32'(count), 32'h0);
    check("async_hit", 32'(hit), 32'd0);
    model_reset();
    Z = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("restart_slot0", 32'(an), 32'hFE);
    repeat (30) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/detect_tally_display.md
Name: detect_tally_display

Overview:
- Downstream consumer of the overlapping "010110" sequence detector outputs (Z, Q), running on the 100 MHz board clock.
- Synchronises Z, which changes in the debounced-clock domain, into the board clock domain and counts each detection in a 4-digit BCD tally.
- Time-multiplexes the tally and the detector state Q onto the board 7-segment display.
- Provides a visible "hit" flash on a decimal point.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the Z and clear synchronisers (minimum 2).
- REFRESH_DIV, 100000, board-clock cycles each digit slot is driven.
- HIT_HOLD, 25000000, board-clock cycles the hit decimal point stays lit after a detection.

Ports:
- clock  input  1  board clock; all state is on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- Z  input  1  detector output; asynchronous to clock.
- Q  input  3  detector state; asynchronous to clock; display only.
- clear  input  1  tally clear button (raw level); asynchronous to clock.
- hit  output  1  one-cycle pulse per detected rising edge of Z.
- count  output  16  tally as four BCD digits: [15:12] thousands … [3:0] units.
- an  output  8  digit anodes, active-low; an[0] is the rightmost digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.

Behaviour:
- Reset (async, active-high): all synchroniser flops, edge register, tally, refresh counter, slot index and hold counter go to 0. Registered outputs take these values: hit=0, count=16'h0000, an=8'hFF, seg=7'h7F, dp=1. Reset may assert at any cycle, including mid-slot or mid-hold; recovery always starts from the reset state above.
- Synchronisers: Z and clear each pass through SYNC_STAGES flops (Zs, Cs). Only Zs and Cs are used downstream.
- Edge detect: register Zd <= Zs. hit is registered: hit <= Zs & ~Zd. Latency is SYNC_STAGES+1 clocks from the Z rise to the hit pulse. Z held high produces exactly one pulse; Z falling produces none.
- Tally: on each cycle where hit=1, count increments in BCD.
  - A digit of 9 rolls to 0 and carries into the next digit.
  - 9999 wraps to 0000 with no flag.
  - While Cs=1, count is held at 0000. Clear wins over a simultaneous hit, and that hit is lost.
  - Each BCD nibble is always in the range 0..9.
- Hold: on hit, hold counter loads HIT_HOLD-1; otherwise it decrements while nonzero. A new hit during hold reloads it (retrigger). dp=0 only while the digit-0 slot is driven and (hold counter ≠ 0 or hit=1); otherwise dp=1.
- Refresh: the refresh counter counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the slot index advances.
  - Slot sequence: 0→1→2→3→4→0. Slots 0..3 show count digits 0..3.
  - Slot 4 shows Q on digit 7, as octal glyph 0..7, with Q resynchronised through two flops.
  - Digits 4..6 are never driven (their an bits are always 1).
- Drive outputs are registered: an, seg and dp reflect the slot index one clock after the index changes. Exactly one an bit is low at any time after the first post-reset clock; all bits are high during reset.
- Glyphs (seg, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any non-BCD value displays as blank (1111111); this is unreachable by design.
- No combinational path from any input to any output.

Test Plan (REFRESH_DIV=4, HIT_HOLD=8, SYNC_STAGES=2):
- Reset held 3 cycles, then released, Z=0 -> hit=0, count=0000, an=FF during reset; an=FE, seg=1000000 within 2 clocks of release.
- Z driven 0→1 and held 50 cycles -> exactly one hit pulse, 3 clocks after the rise; count=0001; dp low on slot-0 frames for 8 cycles, then high.
- 10 Z pulses from count=0009 -> count=0019. Preload to 9999 via 9999 pulses (or a forced tally) plus one more pulse -> count=0000, with no X values on any nibble.
- clear asserted while count=0123, with a Z rise landing the hit on the same cycle Cs goes high -> count=0000 and it stays 0000 while clear is held.
- Q=5 held, observe 5 slots -> an sequence FE,FD,FB,F7,7F repeating every 20 clocks; slot 4 seg=0010010; an[6:4] never low.
- Reset asserted mid-slot-2 with hold active -> an=FF, dp=1, count=0000 immediately (asynchronously); scan restarts at slot 0 after release.
